// File: rtl/wb_pkg.sv
// Write buffer shared types and address helpers.
// Index/tag split matches the read-only cache controller decoder.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int INDEX_W   = 2;
  localparam int TAG_W     = 3;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_index(
    input logic [WB_ADDR_W-1:0] a
  );
    return a[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [WB_ADDR_W-1:0] a
  );
    return a[WB_ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match address comparator over the circular store buffer.
// Scans oldest to youngest so the last hit is the youngest entry.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [ADDR_W-1:0] key_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  idx_o
);

  always_comb begin
    logic [PTR_W-1:0] slot;
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PTR_W'(k);
      if (valid_i[slot] && addr_i[slot] == key_i) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/write_buffer_ctrl.sv
// FIFO store buffer draining CPU stores to RAM, with read
// forwarding, store coalescing, flush and cache invalidation.
module write_buffer_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [ADDR_W-1:0]      i_wr_address,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_flush,
  output logic                   o_flush_done,
  input  logic [ADDR_W-1:0]      i_rd_address,
  output logic                   o_fwd_hit,
  output logic [DATA_W-1:0]      o_fwd_data,
  output logic                   o_ram_wren,
  output logic [ADDR_W-1:0]      o_ram_address,
  output logic [DATA_W-1:0]      o_ram_data,
  input  logic                   i_ram_ready,
  output logic                   o_inv_valid,
  output logic [INDEX_W-1:0]     o_inv_index,
  output logic [TAG_W-1:0]       o_inv_tag,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic             flushing_q, flushing_d;
  logic             done_q, done_d;

  logic [DEPTH-1:0]  valid_vec;
  logic [DEPTH-1:0]  coal_vec;
  logic [ADDR_W-1:0] addr_arr [DEPTH];
  logic              fwd_hit, coal_hit;
  logic [PTR_W-1:0]  fwd_idx, coal_idx;
  logic              full, wr_ready, push, pop;
  logic              alloc, coal, flag_set;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      addr_arr[i]  = ent_q[i].addr;
    end
  end

  // The head being written to RAM must not absorb a coalesced store.
  always_comb begin
    coal_vec = valid_vec;
    if (state_q == WRITE) coal_vec[head_q] = 1'b0;
  end

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .ADDR_W(ADDR_W)
  ) u_fwd (
    .valid_i(valid_vec),
    .addr_i (addr_arr),
    .head_i (head_q),
    .key_i  (i_rd_address),
    .hit_o  (fwd_hit),
    .idx_o  (fwd_idx)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .ADDR_W(ADDR_W)
  ) u_coal (
    .valid_i(coal_vec),
    .addr_i (addr_arr),
    .head_i (head_q),
    .key_i  (i_wr_address),
    .hit_o  (coal_hit),
    .idx_o  (coal_idx)
  );

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    wr_ready = !full && !flushing_q;
    push     = i_wr_valid && wr_ready;
    pop      = (state_q == WRITE) && i_ram_ready;
    coal     = push && coal_hit;
    alloc    = push && !coal_hit;

    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (coal) ent_d[coal_idx].data = i_wr_data;
    if (alloc) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].addr  = i_wr_address;
      ent_d[tail_q].data  = i_wr_data;
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

    state_d = state_q;
    unique case (state_q)
      IDLE:  if (count_q != '0) state_d = WRITE;
      WRITE: if (pop && count_d == '0) state_d = IDLE;
    endcase

    flag_set   = flushing_q || i_flush;
    flushing_d = flag_set && (count_d != '0);
    done_d     = flag_set && (count_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      flushing_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      flushing_q <= flushing_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    o_wr_ready    = wr_ready;
    o_flush_done  = done_q;
    o_count       = count_q;
    o_ram_wren    = (state_q == WRITE);
    o_ram_address = o_ram_wren ? ent_q[head_q].addr : '0;
    o_ram_data    = o_ram_wren ? ent_q[head_q].data : '0;
    o_inv_valid   = pop;
    o_inv_index   = pop ? addr_index(ent_q[head_q].addr) : '0;
    o_inv_tag     = pop ? addr_tag(ent_q[head_q].addr) : '0;
    o_fwd_hit     = fwd_hit;
    o_fwd_data    = fwd_hit ? ent_q[fwd_idx].data : '0;
  end

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// Directed scoreboard bench for write_buffer_ctrl.
// Expected RAM writes are queued at stimulus time, checked on commit.
module tb_write_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [4:0]  rd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        wren;
  logic [4:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_ready = 1'b0;
  logic        inv_valid;
  logic [1:0]  inv_index;
  logic [2:0]  inv_tag;
  logic [2:0]  count;

  write_buffer_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_address (wr_addr),
    .i_wr_data    (wr_data),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .i_rd_address (rd_addr),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_data   (fwd_data),
    .o_ram_wren   (wren),
    .o_ram_address(ram_addr),
    .o_ram_data   (ram_data),
    .i_ram_ready  (ram_ready),
    .o_inv_valid  (inv_valid),
    .o_inv_index  (inv_index),
    .o_inv_tag    (inv_tag),
    .o_count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: coalesce into youngest queued match, skipping a busy head.
  task automatic push_exp(input logic [4:0] a, input logic [31:0] d,
                          input bit head_busy);
    int lo;
    bit hit;
    lo  = head_busy ? 1 : 0;
    hit = 1'b0;
    for (int i = exp_q.size() - 1; i >= lo; i--) begin
      if (!hit && exp_q[i].a == a) begin
        exp_q[i].d = d;
        hit = 1'b1;
      end
    end
    if (!hit) exp_q.push_back('{a: a, d: d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] d,
                       input bit head_busy);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    push_exp(a, d, head_busy);
    cyc();
    wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wren && ram_ready) begin
        if (exp_q.size() == 0) begin
          chk("ram_unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ram_addr", {27'd0, ram_addr}, {27'd0, mon_e.a});
          chk("ram_data", ram_data, mon_e.d);
          chk("inv_valid", {31'd0, inv_valid}, 32'd1);
          chk("inv_index", {30'd0, inv_index}, {30'd0, mon_e.a[1:0]});
          chk("inv_tag", {29'd0, inv_tag}, {29'd0, mon_e.a[4:2]});
        end
      end else begin
        chk("inv_idle", {31'd0, inv_valid}, 32'd0);
      end
    end
  end

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wren", wren, 0);
    chk("rst_inv", inv_valid, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);

    // single store, latency two edges after accept
    ram_ready = 1'b1;
    store(5'h0A, 32'hDEADBEEF, 1'b0);
    chk("t1_count_after_push", count, 1);
    chk("t1_wren_idle", wren, 0);
    cyc();
    chk("t1_wren", wren, 1);
    chk("t1_addr", ram_addr, 32'h0A);
    cyc();
    chk("t1_wren_done", wren, 0);
    chk("t1_count_done", count, 0);

    // fill to full, stall 5th, back-to-back drain
    ram_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      store(5'(5'h10 + i), 32'h100 + i, 1'b1);
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", wr_ready, 0);
    wr_valid = 1'b1;
    wr_addr  = 5'h14;
    wr_data  = 32'h114;
    push_exp(5'h14, 32'h114, 1'b1);
    cyc();
    chk("t2_stall_count", count, 4);
    cyc();
    chk("t2_stall_count2", count, 4);
    chk("t2_wren_held", wren, 1);
    chk("t2_head_addr_held", ram_addr, 32'h10);
    ram_ready = 1'b1;
    cyc();
    chk("t2_pop_no_push", count, 3);
    chk("t2_bubble0", wren, 1);
    cyc();
    wr_valid = 1'b0;
    chk("t2_push_pop", count, 3);
    chk("t2_bubble1", wren, 1);
    cyc();
    chk("t2_count2", count, 2);
    chk("t2_bubble2", wren, 1);
    cyc();
    chk("t2_count1", count, 1);
    chk("t2_bubble3", wren, 1);
    cyc();
    chk("t2_count0", count, 0);
    chk("t2_wren_off", wren, 0);

    // coalescing, and head-match allocation
    ram_ready = 1'b0;
    store(5'h07, 32'hAA, 1'b0);
    store(5'h03, 32'h1, 1'b0);
    store(5'h03, 32'h2, 1'b1);
    chk("t3_coal_count", count, 2);
    store(5'h07, 32'hBB, 1'b1);
    chk("t3_head_alloc_count", count, 3);
    rd_addr = 5'h03;
    #1;
    chk("t3_fwd_hit03", fwd_hit, 1);
    chk("t3_fwd_data03", fwd_data, 32'h2);
    rd_addr = 5'h07;
    #1;
    chk("t3_fwd_young07", fwd_data, 32'hBB);
    ram_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t3_count0", count, 0);
    chk("t3_wren_off", wren, 0);
    ram_ready = 1'b0;

    // forwarding visibility and clearing after commit
    rd_addr  = 5'h05;
    wr_valid = 1'b1;
    wr_addr  = 5'h05;
    wr_data  = 32'h77;
    push_exp(5'h05, 32'h77, 1'b0);
    #1;
    chk("t4_same_cycle_nohit", fwd_hit, 0);
    cyc();
    wr_valid = 1'b0;
    chk("t4_hit", fwd_hit, 1);
    chk("t4_data", fwd_data, 32'h77);
    rd_addr = 5'h06;
    #1;
    chk("t4_other_addr_nohit", fwd_hit, 0);
    rd_addr = 5'h05;
    ram_ready = 1'b1;
    cyc();
    chk("t4_hit_during_write", fwd_hit, 1);
    cyc();
    chk("t4_hit_after_commit", fwd_hit, 0);
    ram_ready = 1'b0;

    // flush with three entries
    store(5'h18, 32'h18, 1'b0);
    store(5'h19, 32'h19, 1'b1);
    store(5'h1A, 32'h1A, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_ready_flush", wr_ready, 0);
    chk("t5_count3", count, 3);
    chk("t5_done0", flush_done, 0);
    ram_ready = 1'b1;
    cyc();
    chk("t5_ready_p1", wr_ready, 0);
    chk("t5_done_p1", flush_done, 0);
    cyc();
    chk("t5_ready_p2", wr_ready, 0);
    chk("t5_done_p2", flush_done, 0);
    chk("t5_count_p2", count, 1);
    cyc();
    chk("t5_count_p3", count, 0);
    chk("t5_done_pulse", flush_done, 1);
    cyc();
    chk("t5_done_clear", flush_done, 0);
    chk("t5_ready_back", wr_ready, 1);

    // flush while empty
    ram_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("t5_empty_pre", flush_done, 0);
    cyc();
    flush = 1'b0;
    chk("t5_empty_pulse", flush_done, 1);
    cyc();
    chk("t5_empty_clear", flush_done, 0);

    // reset during a stalled write
    store(5'h1F, 32'h55, 1'b0);
    cyc();
    chk("t6_wren_pre", wren, 1);
    rst = 1'b1;
    exp_q.delete();
    cyc();
    chk("t6_wren", wren, 0);
    chk("t6_count", count, 0);
    chk("t6_ready", wr_ready, 1);
    chk("t6_ram_addr", ram_addr, 0);
    rst = 1'b0;
    cyc();
    chk("t6_stays_idle", wren, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
